actor_token_fifo: RTL and testbench
===================================

// Module: actor_token_fifo
// PURPOSE
//   Token channel between two dataflow actors. It connects one producer's output
//   port (Out1_SEND/Out1_DATA/Out1_COUNT, waits on Out1_RDY) to one consumer's
//   input port (In1_SEND/In1_DATA/In1_COUNT, pops with In1_ACK). The block buffers
//   tokens in a first-word-fall-through circular FIFO, so the consumer's scheduler
//   sees a token at the head as soon as one is stored.
// PARAMETERS
//   WIDTH  16  token data width in bits
//   DEPTH  8   FIFO capacity in tokens; power of 2, 2..32768
//   AW     3   pointer width, log2(DEPTH)
// PORTS
//   CLK        in   1      clock; all state updates on rising edge
//   RESET      in   1      synchronous reset, active-high
//   In_SEND    in   1      producer offers one token this cycle
//   In_DATA    in   WIDTH  producer token value
//   In_COUNT   in   16     tokens per send; must be 1 whenever In_SEND=1
//   In_RDY     out  1      space available (drives producer Out1_RDY)
//   In_ACK     out  1      token accepted this cycle (drives producer Out1_ACK)
//   Out_SEND   out  1      head token valid (drives consumer In1_SEND)
//   Out_DATA   out  WIDTH  head token value (drives consumer In1_DATA)
//   Out_COUNT  out  16     tokens currently stored (drives consumer In1_COUNT)
//   Out_ACK    in   1      consumer pops the head token this cycle
//   ERR_OVF    out  1      sticky: In_SEND=1 while In_RDY=0
//   ERR_UNF    out  1      sticky: Out_ACK=1 while Out_SEND=0
//   ERR_CNT    out  1      sticky: In_SEND=1 with In_COUNT != 1
// BEHAVIOUR
//   State: mem[DEPTH], wr_ptr/rd_ptr (AW bits), occ (AW+1 bits).
//   Reset: RESET=1 at a clock edge sets wr_ptr=rd_ptr=occ=0 and clears all ERR_*.
//     - mem contents are not reset.
//     - Outputs after reset: In_RDY=1, Out_SEND=0, Out_COUNT=0, In_ACK=0.
//     - Reset mid-transfer discards every stored token. A push or pop in the same
//       cycle as RESET is ignored.
//   Combinational outputs:
//     - In_RDY = (occ != DEPTH); depends only on registered state.
//     - In_ACK = In_SEND & In_RDY.
//     - Out_SEND = (occ != 0).
//     - Out_DATA = mem[rd_ptr]. It is undefined when Out_SEND=0, and it changes
//       only on a pop or on a write into an empty FIFO.
//     - Out_COUNT = occ, zero-extended to 16 bits.
//   Push = In_ACK:
//     - mem[wr_ptr] <= In_DATA; wr_ptr <= wr_ptr+1, mod DEPTH.
//     - ERR_CNT can set, but the token is still stored as a single token.
//   Pop = Out_ACK & Out_SEND: rd_ptr <= rd_ptr+1, mod DEPTH.
//   Occupancy: occ <= occ + push - pop.
//     - Push and pop together leave occ unchanged.
//     - They are legal together at any occupancy that permits each one
//       individually.
//   Full (occ=DEPTH): In_RDY=0 even if a pop happens the same cycle, so there is
//     no pass-through on full. A refused In_SEND sets ERR_OVF and does not alter
//     state.
//   Empty (occ=0): Out_ACK is ignored and sets ERR_UNF. A same-cycle push is
//     accepted. The token appears on Out_SEND/Out_DATA one cycle later, so latency
//     from push to head-valid is 1 cycle.
//   Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble. Throughput is
//     1 token/cycle sustained while occ is in 1..DEPTH-1.
//   Ordering: strict FIFO; no token lost or duplicated without an ERR_* flag.
// TESTING
//   1. Reset then idle: RESET=1 for 2 cycles, then 0.
//      -> In_RDY=1, Out_SEND=0, Out_COUNT=0, ERR_*=0.
//   2. Single token: push 16'hA5A5 at cycle t.
//      -> In_ACK=1 at t; Out_SEND=1, Out_DATA=A5A5, Out_COUNT=1 at t+1.
//      Then Out_ACK=1 -> Out_SEND=0 next cycle.
//   3. Fill, DEPTH=8: push 1..8 with no pops.
//      -> Out_COUNT=8, In_RDY=0.
//      9th push -> In_ACK=0 and ERR_OVF=1; the pops that follow return 1..8 in
//      order.
//   4. Streaming with wrap: push and pop 20 tokens (0x100+i) simultaneously every
//      cycle after the first push.
//      -> Out_COUNT stays 1, outputs match in order, no ERR_*.
//   5. Empty pop plus push: at occ=0, Out_ACK=1 and push 16'h0042 together.
//      -> ERR_UNF=1; the token is stored; next cycle Out_DATA=0042, Out_COUNT=1.
//   6. Reset mid-stream: at occ=5, RESET=1 with In_SEND=1.
//      -> next cycle occ=0, Out_SEND=0, and the pushed token is discarded.
//      Separately, In_COUNT=2 with In_SEND=1 -> ERR_CNT=1.

Source files
------------

// File: rtl/actor_token_fifo.sv
// Token channel between a producer and a consumer actor: a first-word-fall-through
// circular FIFO with sticky protocol-violation flags.
module actor_token_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             In_SEND,
  input  logic [WIDTH-1:0] In_DATA,
  input  logic [15:0]      In_COUNT,
  output logic             In_RDY,
  output logic             In_ACK,
  output logic             Out_SEND,
  output logic [WIDTH-1:0] Out_DATA,
  output logic [15:0]      Out_COUNT,
  input  logic             Out_ACK,
  output logic             ERR_OVF,
  output logic             ERR_UNF,
  output logic             ERR_CNT
);

  localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   occ_reg, occ_next;
  logic          err_ovf_reg, err_ovf_next;
  logic          err_unf_reg, err_unf_next;
  logic          err_cnt_reg, err_cnt_next;

  logic push;
  logic pop;

  // Readiness looks only at stored occupancy, so a full FIFO refuses a push
  // even when the consumer pops in the same cycle.
  assign In_RDY    = (occ_reg != FULL_OCC);
  assign In_ACK    = In_SEND & In_RDY;
  assign Out_SEND  = (occ_reg != '0);
  assign Out_DATA  = mem[rd_ptr_reg];
  assign Out_COUNT = 16'(occ_reg);

  assign ERR_OVF = err_ovf_reg;
  assign ERR_UNF = err_unf_reg;
  assign ERR_CNT = err_cnt_reg;

  assign push = In_ACK;
  assign pop  = Out_ACK & Out_SEND;

  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    occ_next     = occ_reg;
    err_ovf_next = err_ovf_reg;
    err_unf_next = err_unf_reg;
    err_cnt_next = err_cnt_reg;

    if (push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end

    case ({push, pop})
      2'b10:   occ_next = occ_reg + (AW + 1)'(1);
      2'b01:   occ_next = occ_reg - (AW + 1)'(1);
      default: occ_next = occ_reg;
    endcase

    if (In_SEND && !In_RDY) begin
      err_ovf_next = 1'b1;
    end
    if (Out_ACK && !Out_SEND) begin
      err_unf_next = 1'b1;
    end
    // A multi-token send is flagged but still stored as a single token.
    if (In_SEND && (In_COUNT != 16'd1)) begin
      err_cnt_next = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      occ_reg     <= '0;
      err_ovf_reg <= 1'b0;
      err_unf_reg <= 1'b0;
      err_cnt_reg <= 1'b0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      occ_reg     <= occ_next;
      err_ovf_reg <= err_ovf_next;
      err_unf_reg <= err_unf_next;
      err_cnt_reg <= err_cnt_next;
    end
  end

  // Storage is never cleared; a write that coincides with reset is dropped.
  always_ff @(posedge CLK) begin
    if (push && !RESET) begin
      mem[wr_ptr_reg] <= In_DATA;
    end
  end

endmodule

// File: tb/tb_actor_token_fifo.sv
// Self-checking bench for actor_token_fifo: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_actor_token_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             CLK;
  logic             RESET;
  logic             In_SEND;
  logic [WIDTH-1:0] In_DATA;
  logic [15:0]      In_COUNT;
  logic             In_RDY;
  logic             In_ACK;
  logic             Out_SEND;
  logic [WIDTH-1:0] Out_DATA;
  logic [15:0]      Out_COUNT;
  logic             Out_ACK;
  logic             ERR_OVF;
  logic             ERR_UNF;
  logic             ERR_CNT;

  int n_checks;
  int n_fail;

  // Reference model: the stored tokens in arrival order plus the sticky flags.
  int unsigned q[$];
  bit m_ovf, m_unf, m_cnt;

  actor_token_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .In_SEND(In_SEND),
    .In_DATA(In_DATA),
    .In_COUNT(In_COUNT),
    .In_RDY(In_RDY),
    .In_ACK(In_ACK),
    .Out_SEND(Out_SEND),
    .Out_DATA(Out_DATA),
    .Out_COUNT(Out_COUNT),
    .Out_ACK(Out_ACK),
    .ERR_OVF(ERR_OVF),
    .ERR_UNF(ERR_UNF),
    .ERR_CNT(ERR_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Apply inputs shortly after a rising edge and let them settle.
  task automatic drive(input bit snd, input logic [15:0] dat, input logic [15:0] cnt,
                       input bit ack, input bit rst);
    In_SEND  = snd;
    In_DATA  = dat;
    In_COUNT = cnt;
    Out_ACK  = ack;
    RESET    = rst;
    #2;
  endtask

  // Advance the model with the current inputs, then clock the DUT.
  task automatic step();
    bit has_room;
    bit has_data;
    has_room = (q.size() != DEPTH);
    has_data = (q.size() != 0);
    $display("t=%0t rst=%b send=%b data=%h cnt=%0d ack=%b occ_before=%0d",
             $time, RESET, In_SEND, In_DATA, In_COUNT, Out_ACK, q.size());
    if (RESET) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
      m_cnt = 0;
    end else begin
      if (In_SEND && !has_room) m_ovf = 1;
      if (Out_ACK && !has_data) m_unf = 1;
      if (In_SEND && In_COUNT != 16'd1) m_cnt = 1;
      if (Out_ACK && has_data) void'(q.pop_front());
      if (In_SEND && has_room) q.push_back(int'(In_DATA));
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 16'h0, 16'd1, 0, 1);
    step();
    drive(0, 16'h0, 16'd1, 0, 0);
  endtask

  task automatic test_reset();
    drive(0, 16'h0, 16'd1, 0, 1);
    step();
    drive(0, 16'h0, 16'd1, 0, 1);
    step();
    drive(0, 16'h0, 16'd1, 0, 0);
    n_checks++;
    if (In_RDY !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_rdy: got %b want 1", In_RDY);
    end
    n_checks++;
    if (Out_SEND !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_send: got %b want 0", Out_SEND);
    end
    n_checks++;
    if (Out_COUNT !== 16'd0) begin
      n_fail++; $display("FAIL reset_out_count: got %0d want 0", Out_COUNT);
    end
    n_checks++;
    if (In_ACK !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ack: got %b want 0", In_ACK);
    end
    n_checks++;
    if ({ERR_OVF, ERR_UNF, ERR_CNT} !== 3'b000) begin
      n_fail++; $display("FAIL reset_errs: got %b want 000", {ERR_OVF, ERR_UNF, ERR_CNT});
    end
  endtask

  task automatic test_single();
    drive(1, 16'hA5A5, 16'd1, 0, 0);
    n_checks++;
    if (In_ACK !== 1'b1) begin
      n_fail++; $display("FAIL single_in_ack: got %b want 1", In_ACK);
    end
    step();
    drive(0, 16'h0, 16'd1, 0, 0);
    n_checks++;
    if (Out_SEND !== 1'b1 || Out_DATA !== 16'hA5A5 || Out_COUNT !== 16'd1) begin
      n_fail++; $display("FAIL single_head: got send=%b data=%h count=%0d want 1 a5a5 1",
                         Out_SEND, Out_DATA, Out_COUNT);
    end
    drive(0, 16'h0, 16'd1, 1, 0);
    step();
    drive(0, 16'h0, 16'd1, 0, 0);
    n_checks++;
    if (Out_SEND !== 1'b0) begin
      n_fail++; $display("FAIL single_pop: got send=%b want 0", Out_SEND);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1, 16'(i), 16'd1, 0, 0);
      step();
    end
    drive(0, 16'h0, 16'd1, 0, 0);
    n_checks++;
    if (Out_COUNT !== 16'(DEPTH) || In_RDY !== 1'b0) begin
      n_fail++; $display("FAIL fill_full: got count=%0d rdy=%b want %0d 0",
                         Out_COUNT, In_RDY, DEPTH);
    end
    // Overflow attempt with a simultaneous pop: still refused.
    drive(1, 16'd9, 16'd1, 1, 0);
    n_checks++;
    if (In_ACK !== 1'b0) begin
      n_fail++; $display("FAIL fill_ovf_ack: got %b want 0", In_ACK);
    end
    step();
    drive(0, 16'h0, 16'd1, 0, 0);
    n_checks++;
    if (ERR_OVF !== 1'b1 || Out_COUNT !== 16'(DEPTH - 1)) begin
      n_fail++; $display("FAIL fill_ovf_flag: got ovf=%b count=%0d want 1 %0d",
                         ERR_OVF, Out_COUNT, DEPTH - 1);
    end
    for (int i = 2; i <= DEPTH; i++) begin
      drive(0, 16'h0, 16'd1, 1, 0);
      n_checks++;
      if (Out_SEND !== 1'b1 || Out_DATA !== 16'(i)) begin
        n_fail++; $display("FAIL fill_order: got send=%b data=%h want 1 %h",
                           Out_SEND, Out_DATA, 16'(i));
      end
      step();
    end
    drive(0, 16'h0, 16'd1, 0, 0);
    n_checks++;
    if (Out_SEND !== 1'b0) begin
      n_fail++; $display("FAIL fill_drained: got send=%b want 0", Out_SEND);
    end
    do_reset();
  endtask

  task automatic test_stream();
    drive(1, 16'h0100, 16'd1, 0, 0);
    step();
    for (int i = 1; i < 20; i++) begin
      drive(1, 16'(16'h0100 + i), 16'd1, 1, 0);
      n_checks++;
      if (Out_COUNT !== 16'd1 || Out_DATA !== 16'(16'h0100 + i - 1) || In_ACK !== 1'b1) begin
        n_fail++; $display("FAIL stream_%0d: got count=%0d data=%h ack=%b want 1 %h 1",
                           i, Out_COUNT, Out_DATA, In_ACK, 16'(16'h0100 + i - 1));
      end
      step();
    end
    drive(0, 16'h0, 16'd1, 1, 0);
    n_checks++;
    if (Out_DATA !== 16'h0113) begin
      n_fail++; $display("FAIL stream_last: got %h want 0113", Out_DATA);
    end
    step();
    drive(0, 16'h0, 16'd1, 0, 0);
    n_checks++;
    if ({ERR_OVF, ERR_UNF, ERR_CNT} !== 3'b000 || Out_SEND !== 1'b0) begin
      n_fail++; $display("FAIL stream_errs: got errs=%b send=%b want 000 0",
                         {ERR_OVF, ERR_UNF, ERR_CNT}, Out_SEND);
    end
  endtask

  task automatic test_empty_pop_push();
    drive(1, 16'h0042, 16'd1, 1, 0);
    n_checks++;
    if (In_ACK !== 1'b1) begin
      n_fail++; $display("FAIL emptypop_ack: got %b want 1", In_ACK);
    end
    step();
    drive(0, 16'h0, 16'd1, 0, 0);
    n_checks++;
    if (ERR_UNF !== 1'b1 || Out_DATA !== 16'h0042 || Out_COUNT !== 16'd1) begin
      n_fail++; $display("FAIL emptypop_state: got unf=%b data=%h count=%0d want 1 0042 1",
                         ERR_UNF, Out_DATA, Out_COUNT);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      drive(1, 16'(16'h0200 + i), 16'd1, 0, 0);
      step();
    end
    drive(1, 16'h0777, 16'd1, 1, 1);
    step();
    drive(0, 16'h0, 16'd1, 0, 0);
    n_checks++;
    if (Out_COUNT !== 16'd0 || Out_SEND !== 1'b0 || In_RDY !== 1'b1) begin
      n_fail++; $display("FAIL resetmid_empty: got count=%0d send=%b rdy=%b want 0 0 1",
                         Out_COUNT, Out_SEND, In_RDY);
    end
    drive(1, 16'h0055, 16'd1, 0, 0);
    step();
    drive(0, 16'h0, 16'd1, 0, 0);
    n_checks++;
    if (Out_DATA !== 16'h0055 || Out_COUNT !== 16'd1) begin
      n_fail++; $display("FAIL resetmid_next: got data=%h count=%0d want 0055 1",
                         Out_DATA, Out_COUNT);
    end
    do_reset();
  endtask

  task automatic test_count_err();
    drive(1, 16'h0033, 16'd2, 0, 0);
    step();
    drive(0, 16'h0, 16'd1, 0, 0);
    n_checks++;
    if (ERR_CNT !== 1'b1 || Out_COUNT !== 16'd1 || Out_DATA !== 16'h0033) begin
      n_fail++; $display("FAIL count_err: got cnt=%b count=%0d data=%h want 1 1 0033",
                         ERR_CNT, Out_COUNT, Out_DATA);
    end
    n_checks++;
    if (ERR_OVF !== 1'b0 || ERR_UNF !== 1'b0) begin
      n_fail++; $display("FAIL count_err_others: got ovf=%b unf=%b want 0 0", ERR_OVF, ERR_UNF);
    end
    do_reset();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bit snd, ack, rst;
      logic [15:0] dat, cnt;
      bit exp_room;
      snd = ($urandom_range(0, 99) < 55);
      ack = ($urandom_range(0, 99) < 45);
      rst = ($urandom_range(0, 63) == 0);
      dat = 16'($urandom);
      cnt = ($urandom_range(0, 31) == 0) ? 16'd2 : 16'd1;
      drive(snd, dat, cnt, ack, rst);
      exp_room = (q.size() != DEPTH);
      n_checks++;
      if (In_RDY !== exp_room || In_ACK !== (snd & exp_room) ||
          Out_SEND !== (q.size() != 0) || Out_COUNT !== 16'(q.size())) begin
        n_fail++; $display("FAIL rand_status_%0d: got rdy=%b ack=%b send=%b count=%0d want %b %b %b %0d",
                           n, In_RDY, In_ACK, Out_SEND, Out_COUNT,
                           exp_room, snd & exp_room, q.size() != 0, q.size());
      end
      if (q.size() != 0) begin
        n_checks++;
        if (Out_DATA !== 16'(q[0])) begin
          n_fail++; $display("FAIL rand_data_%0d: got %h want %h", n, Out_DATA, 16'(q[0]));
        end
      end
      n_checks++;
      if ({ERR_OVF, ERR_UNF, ERR_CNT} !== {m_ovf, m_unf, m_cnt}) begin
        n_fail++; $display("FAIL rand_errs_%0d: got %b want %b", n,
                           {ERR_OVF, ERR_UNF, ERR_CNT}, {m_ovf, m_unf, m_cnt});
      end
      step();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_ovf = 0;
    m_unf = 0;
    m_cnt = 0;
    In_SEND  = 1'b0;
    In_DATA  = '0;
    In_COUNT = 16'd1;
    Out_ACK  = 1'b0;
    RESET    = 1'b1;
    @(posedge CLK);
    #1;
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_empty_pop_push();
    test_reset_mid();
    test_count_err();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
